mips_dmem_responder: RTL and testbench

- Data-memory responder for the I-type load/store path: the target side of lw/sw memory accesses.
- Accepts one request at a time over a valid/ready handshake and performs the access after a programmable number of wait cycles.
- Returns load data, or a store acknowledgement, over a second valid/ready handshake.
- Replaces the zero-latency array access in the datapath so the CPU can be exercised against a realistic, stalling memory.

---
 rtl/mips_dmem_if.sv | 15 +
 rtl/mips_dmem_responder.sv | 80 ++++++++
 tb/tb_mips_dmem_responder.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/mips_dmem_if.sv
// mips_dmem_if: request/response handshake bundle between the load/store unit and data memory
interface mips_dmem_if;
    logic        req_valid, req_ready, req_we;
    logic [31:0] req_addr, req_wdata;
    logic        rsp_valid, rsp_ready, rsp_we, rsp_err;
    logic [31:0] rsp_rdata;
    modport master (
        output req_valid, req_we, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_we, rsp_err
    );
    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_we, rsp_err
    );
endinterface

// File: rtl/mips_dmem_responder.sv
// mips_dmem_responder: stalling lw/sw data memory with a fixed accept-to-response latency
// Memory resets to mem[i] = i so loads are predictable right out of reset.
module mips_dmem_responder #(
    parameter int DEPTH   = 32,
    parameter int ADDR_W  = 5,
    parameter int LATENCY = 2
) (
    input logic       clk,
    input logic       rst_n,
    mips_dmem_if.slave bus
);
    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              we_q, rsp_we_q, rsp_err_q;
    logic [31:0]       addr_q, wdata_q, rdata_q;
    logic [31:0]       mem_q [DEPTH];
    logic              accept, commit, in_range;
    logic [ADDR_W-1:0] idx;
    assign idx           = addr_q[ADDR_W-1:0];
    assign in_range      = addr_q[31:ADDR_W] == '0;
    assign bus.req_ready = state_q == IDLE;
    assign bus.rsp_valid = state_q == RESP;
    assign bus.rsp_rdata = rdata_q;
    assign bus.rsp_we    = rsp_we_q;
    assign bus.rsp_err   = rsp_err_q;
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        accept  = 1'b0;
        commit  = 1'b0;
        case (state_q)
            IDLE: if (bus.req_valid) begin
                accept  = 1'b1;
                cnt_d   = 4'(LATENCY - 1);
                state_d = BUSY;
            end
            BUSY: if (cnt_q != 4'd0) cnt_d = cnt_q - 4'd1;
                  else begin
                      commit  = 1'b1;
                      state_d = RESP;
                  end
            RESP: if (bus.rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            rsp_we_q  <= 1'b0;
            rsp_err_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                we_q    <= bus.req_we;
                addr_q  <= bus.req_addr;
                wdata_q <= bus.req_wdata;
            end
            // Stores and out-of-range accesses return zero data.
            if (commit) begin
                rdata_q   <= (we_q || !in_range) ? '0 : mem_q[idx];
                rsp_we_q  <= we_q;
                rsp_err_q <= !in_range;
            end
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= 32'(i);
        end else if (commit && we_q && in_range) begin
            mem_q[idx] <= wdata_q;
        end
    end
endmodule

// File: tb/tb_mips_dmem_responder.sv
// tb_mips_dmem_responder: vector table plus corner sequences, checked through an expected-response queue
module tb_mips_dmem_responder;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic sweep_go = 1'b0;
    int   cyc = 0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mips_dmem_if bus();
    mips_dmem_responder #(.DEPTH(32), .ADDR_W(5), .LATENCY(2)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    for (genvar g = 0; g < 2; g++) begin : sw
        mips_dmem_if sb();
        int          n_acc = 0, n_rsp = 0, acc_e = 0;
        int          lat [4];
        logic [31:0] dat [4];
        mips_dmem_responder #(.DEPTH(32), .ADDR_W(5), .LATENCY(g ? 15 : 1)) u (.clk(clk), .rst_n(rst_n), .bus(sb));
        assign sb.req_valid = sweep_go && n_acc < 4;
        assign sb.req_we    = 1'b0;
        assign sb.req_addr  = 32'(n_acc);
        assign sb.req_wdata = '0;
        assign sb.rsp_ready = 1'b1;
        always @(posedge clk) if (sb.req_valid && sb.req_ready) begin
            acc_e <= cyc;
            n_acc <= n_acc + 1;
        end
        always @(negedge clk) if (n_rsp < n_acc && n_rsp < 4 && sb.rsp_valid) begin
            lat[n_rsp] = cyc - 1 - acc_e;
            dat[n_rsp] = sb.rsp_rdata;
            n_rsp++;
        end
    end

    typedef struct {
        logic        we;
        logic [31:0] addr, wdata, rdata;
        logic        err;
    } vec_t;
    vec_t vecs [11];
    vec_t sb_q [$];
    int   n_chk = 0, n_fail = 0, acc_edge = 0;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(logic we, logic [31:0] addr, logic [31:0] wdata, logic [31:0] rdata, logic err);
        vec_t v;
        v.we = we; v.addr = addr; v.wdata = wdata; v.rdata = rdata; v.err = err;
        return v;
    endfunction

    task automatic send(vec_t v);
        bus.req_valid = 1'b1;
        bus.req_we    = v.we;
        bus.req_addr  = v.addr;
        bus.req_wdata = v.wdata;
        for (int k = 0; k < 50 && !bus.req_ready; k++) @(negedge clk);
        chk("req_ready_before_accept", 32'(bus.req_ready), 32'd1);
        sb_q.push_back(v);
        @(posedge clk);
        acc_edge = cyc;
        @(negedge clk);
        bus.req_valid = 1'b0;
    endtask

    task automatic wait_rsp(string tag);
        vec_t e;
        for (int k = 0; k < 50 && !bus.rsp_valid; k++) @(negedge clk);
        chk({tag, " rsp_valid"}, 32'(bus.rsp_valid), 32'd1);
        if (sb_q.size() == 0) begin
            chk({tag, " scoreboard_nonempty"}, 32'd0, 32'd1);
            return;
        end
        e = sb_q.pop_front();
        chk({tag, " latency"}, 32'(cyc - 1 - acc_edge), 32'd2);
        chk({tag, " rdata"}, bus.rsp_rdata, e.rdata);
        chk({tag, " err"}, 32'(bus.rsp_err), 32'(e.err));
        chk({tag, " we"}, 32'(bus.rsp_we), 32'(e.we));
        if (bus.rsp_ready) begin
            @(negedge clk);
            chk({tag, " valid_drop"}, 32'(bus.rsp_valid), 32'd0);
            chk({tag, " req_ready_back"}, 32'(bus.req_ready), 32'd1);
            chk({tag, " rdata_kept"}, bus.rsp_rdata, e.rdata);
        end
    endtask

    initial begin
        logic seen;
        bus.req_valid = 1'b0;
        bus.req_we    = 1'b0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        bus.rsp_ready = 1'b1;
        vecs[0]  = mk(1'b0, 32'd7,          32'h0,        32'd7,        1'b0);
        vecs[1]  = mk(1'b1, 32'd3,          32'hDEADBEEF, 32'h0,        1'b0);
        vecs[2]  = mk(1'b0, 32'd3,          32'h0,        32'hDEADBEEF, 1'b0);
        vecs[3]  = mk(1'b0, 32'd4,          32'h0,        32'd4,        1'b0);
        vecs[4]  = mk(1'b1, 32'h20,         32'h55,       32'h0,        1'b1);
        vecs[5]  = mk(1'b0, 32'd0,          32'h0,        32'h0,        1'b0);
        vecs[6]  = mk(1'b0, 32'd1,          32'h0,        32'd1,        1'b0);
        vecs[7]  = mk(1'b0, 32'd31,         32'h0,        32'd31,       1'b0);
        vecs[8]  = mk(1'b0, 32'h80000000,   32'h0,        32'h0,        1'b1);
        vecs[9]  = mk(1'b1, 32'd31,         32'h12345678, 32'h0,        1'b0);
        vecs[10] = mk(1'b0, 32'd31,         32'h0,        32'h12345678, 1'b0);
        repeat (2) @(negedge clk);
        chk("reset req_ready", 32'(bus.req_ready), 32'd1);
        chk("reset rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("reset rsp_rdata", bus.rsp_rdata, 32'd0);
        chk("reset rsp_we", 32'(bus.rsp_we), 32'd0);
        chk("reset rsp_err", 32'(bus.rsp_err), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 11; i++) begin
            send(vecs[i]);
            wait_rsp($sformatf("vec%0d", i));
        end
        // Backpressure: response held five cycles while a second request waits.
        bus.rsp_ready = 1'b0;
        send(mk(1'b0, 32'd12, 32'h0, 32'd12, 1'b0));
        wait_rsp("bp");
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b0;
        bus.req_addr  = 32'd5;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk($sformatf("bp hold%0d valid", i), 32'(bus.rsp_valid), 32'd1);
            chk($sformatf("bp hold%0d rdata", i), bus.rsp_rdata, 32'd12);
            chk($sformatf("bp hold%0d req_ready", i), 32'(bus.req_ready), 32'd0);
        end
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        chk("bp after_hs valid", 32'(bus.rsp_valid), 32'd0);
        chk("bp after_hs req_ready", 32'(bus.req_ready), 32'd1);
        chk("bp after_hs rdata", bus.rsp_rdata, 32'd12);
        sb_q.push_back(mk(1'b0, 32'd5, 32'h0, 32'd5, 1'b0));
        @(posedge clk);
        acc_edge = cyc;
        @(negedge clk);
        bus.req_valid = 1'b0;
        wait_rsp("held_req");
        // Reset during BUSY drops the store and re-initialises memory.
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b1;
        bus.req_addr  = 32'd9;
        bus.req_wdata = 32'hAA;
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        rst_n = 1'b0;
        seen = 1'b0;
        repeat (3) begin
            @(negedge clk);
            seen |= bus.rsp_valid;
        end
        rst_n = 1'b1;
        repeat (4) begin
            @(negedge clk);
            seen |= bus.rsp_valid;
        end
        chk("midreset no_rsp", 32'(seen), 32'd0);
        chk("midreset req_ready", 32'(bus.req_ready), 32'd1);
        send(mk(1'b0, 32'd9, 32'h0, 32'd9, 1'b0));
        wait_rsp("ld9_after_reset");
        send(mk(1'b0, 32'd3, 32'h0, 32'd3, 1'b0));
        wait_rsp("ld3_after_reset");
        // Latency sweep on the LATENCY=1 and LATENCY=15 instances.
        sweep_go = 1'b1;
        for (int k = 0; k < 300 && (sw[0].n_rsp < 4 || sw[1].n_rsp < 4); k++) @(negedge clk);
        chk("sweep L1 count", 32'(sw[0].n_rsp), 32'd4);
        chk("sweep L15 count", 32'(sw[1].n_rsp), 32'd4);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("sweep L1 lat%0d", i), 32'(sw[0].lat[i]), 32'd1);
            chk($sformatf("sweep L1 data%0d", i), sw[0].dat[i], 32'(i));
            chk($sformatf("sweep L15 lat%0d", i), 32'(sw[1].lat[i]), 32'd15);
            chk($sformatf("sweep L15 data%0d", i), sw[1].dat[i], 32'(i));
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
